// File: rtl/tx_preamble_mux.sv
// rtl/tx_preamble_mux.sv - frame sequencer muxing short/long training and payload samples
// Every output is registered; each generator is gated by a one-hot ACK that tracks the FSM state.
module tx_preamble_mux #(
    parameter int SHORT_LEN = 320,
    parameter int LONG_LEN  = 320,
    parameter int STALL_MAX = 1023
) (
    input  logic        SYS_CLK,
    input  logic        PHY_RST,
    input  logic        TX_START,
    input  logic [27:0] SHORT_TRAINING_SEQ,
    input  logic        SHORT_TRAINING_SEQ_VALID,
    input  logic [27:0] LONG_TRAINING_SEQ,
    input  logic        LONG_TRAINING_SEQ_VALID,
    input  logic [27:0] DATA_SYM,
    input  logic        DATA_SYM_VALID,
    input  logic        DATA_SYM_LAST,
    output logic        SHORT_ACK,
    output logic        LONG_ACK,
    output logic        DATA_ACK,
    output logic [27:0] TX_SAMPLE,
    output logic        TX_SAMPLE_VALID,
    output logic [11:0] TX_SAMPLE_INDEX,
    output logic        TX_BUSY,
    output logic        TX_DONE,
    output logic        TX_ABORT
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SHORT = 3'd1,
        ST_LONG  = 3'd2,
        ST_DATA  = 3'd3,
        ST_END   = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [9:0]  stall_q, stall_d;
    logic [11:0] next_idx_q, next_idx_d;
    logic        short_ack_q, short_ack_d;
    logic        long_ack_q, long_ack_d;
    logic        data_ack_q, data_ack_d;
    logic [27:0] sample_q, sample_d;
    logic        sample_valid_q, sample_valid_d;
    logic [11:0] sample_index_q, sample_index_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        abort_q, abort_d;

    logic        accept;
    logic [27:0] accept_data;
    logic        start_frame;
    logic        abort_evt;

    always_ff @(posedge SYS_CLK or posedge PHY_RST) begin
        if (PHY_RST) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            stall_q        <= '0;
            next_idx_q     <= '0;
            short_ack_q    <= 1'b0;
            long_ack_q     <= 1'b0;
            data_ack_q     <= 1'b0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            sample_index_q <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            abort_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            stall_q        <= stall_d;
            next_idx_q     <= next_idx_d;
            short_ack_q    <= short_ack_d;
            long_ack_q     <= long_ack_d;
            data_ack_q     <= data_ack_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
            sample_index_q <= sample_index_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            abort_q        <= abort_d;
        end
    end

    // Acceptance keys on state_q, so samples still in flight after an ACK drop fall through.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stall_d     = '0;
        next_idx_d  = next_idx_q;
        accept      = 1'b0;
        accept_data = '0;
        start_frame = 1'b0;
        abort_evt   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (TX_START) begin
                    state_d     = ST_SHORT;
                    cnt_d       = '0;
                    next_idx_d  = '0;
                    start_frame = 1'b1;
                end
            end
            ST_SHORT: begin
                if (SHORT_TRAINING_SEQ_VALID) begin
                    accept      = 1'b1;
                    accept_data = SHORT_TRAINING_SEQ;
                    if (cnt_q == 16'(SHORT_LEN - 1)) begin
                        state_d = ST_LONG;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            ST_LONG: begin
                if (LONG_TRAINING_SEQ_VALID) begin
                    accept      = 1'b1;
                    accept_data = LONG_TRAINING_SEQ;
                    if (cnt_q == 16'(LONG_LEN - 1)) begin
                        state_d = ST_DATA;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            ST_DATA: begin
                if (DATA_SYM_VALID) begin
                    accept      = 1'b1;
                    accept_data = DATA_SYM;
                    if (DATA_SYM_LAST) begin
                        state_d = ST_END;
                    end
                end else if (stall_q == 10'(STALL_MAX - 1)) begin
                    abort_evt = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    stall_d = stall_q + 10'd1;
                end
            end
            ST_END: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (accept) begin
            next_idx_d = next_idx_q + 12'd1;
        end
    end

    always_comb begin
        short_ack_d    = (state_d == ST_SHORT);
        long_ack_d     = (state_d == ST_LONG);
        data_ack_d     = (state_d == ST_DATA);
        busy_d         = (state_d != ST_IDLE);
        done_d         = (state_d == ST_END);
        abort_d        = abort_evt;
        sample_valid_d = accept;
        sample_d       = accept ? accept_data : '0;
        sample_index_d = sample_index_q;
        if (start_frame) begin
            sample_index_d = '0;
        end else if (accept) begin
            sample_index_d = next_idx_q;
        end
    end

    assign SHORT_ACK       = short_ack_q;
    assign LONG_ACK        = long_ack_q;
    assign DATA_ACK        = data_ack_q;
    assign TX_SAMPLE       = sample_q;
    assign TX_SAMPLE_VALID = sample_valid_q;
    assign TX_SAMPLE_INDEX = sample_index_q;
    assign TX_BUSY         = busy_q;
    assign TX_DONE         = done_q;
    assign TX_ABORT        = abort_q;

endmodule

// File: doc/tx_preamble_mux.md
TX_PREAMBLE_MUX -- requirements
Module: tx_preamble_mux

Interface
REQ-001 Parameter SHORT_LEN, default 320: number of short-training samples accepted per frame.
REQ-002 Parameter LONG_LEN, default 320: number of long-training samples accepted per frame.
REQ-003 Parameter STALL_MAX, default 1023: maximum idle cycles allowed in the DATA state before an abort.
REQ-004 Port SYS_CLK, input, 1: the single clock; all state changes on its rising edge.
REQ-005 Port PHY_RST, input, 1: reset, asynchronous and active-high.
REQ-006 Port TX_START, input, 1: single-cycle frame start request.
REQ-007 Port SHORT_TRAINING_SEQ, input, 28: short preamble sample, Q1.3.24 signed.
REQ-008 Port SHORT_TRAINING_SEQ_VALID, input, 1: short sample qualifier.
REQ-009 Port LONG_TRAINING_SEQ, input, 28: long preamble sample, same format.
REQ-010 Port LONG_TRAINING_SEQ_VALID, input, 1: long sample qualifier.
REQ-011 Port DATA_SYM, input, 28: payload time-domain sample.
REQ-012 Port DATA_SYM_VALID, input, 1: payload sample qualifier.
REQ-013 Port DATA_SYM_LAST, input, 1: marks the final payload sample; meaningful only with DATA_SYM_VALID.
REQ-014 Port SHORT_ACK, output, 1: enables the short-training generator.
REQ-015 Port LONG_ACK, output, 1: enables the long-training generator.
REQ-016 Port DATA_ACK, output, 1: enables the payload source.
REQ-017 Port TX_SAMPLE, output, 28: multiplexed sample toward the DAC path.
REQ-018 Port TX_SAMPLE_VALID, output, 1: TX_SAMPLE qualifier.
REQ-019 Port TX_SAMPLE_INDEX, output, 12: running sample index within the frame, starting at 0.
REQ-020 Port TX_BUSY, output, 1: high in every state except IDLE.
REQ-021 Port TX_DONE, output, 1: one-cycle pulse on normal frame completion.
REQ-022 Port TX_ABORT, output, 1: one-cycle pulse on stall abort.

Function
REQ-023 The FSM shall have the states IDLE, SHORT, LONG, DATA and END, and all outputs shall be registered.
REQ-024 In IDLE, TX_START=1 shall move the FSM to SHORT, assert SHORT_ACK from the next cycle, and clear the sample counter and TX_SAMPLE_INDEX.
REQ-025 In SHORT, each cycle with SHORT_TRAINING_SEQ_VALID=1 shall register TX_SAMPLE=SHORT_TRAINING_SEQ and TX_SAMPLE_VALID=1 one cycle later, increment TX_SAMPLE_INDEX, and increment the sample counter.
REQ-026 On the accepted short sample with counter=SHORT_LEN-1, the block shall deassert SHORT_ACK, assert LONG_ACK, clear the counter, and enter LONG.
REQ-027 In LONG, sample acceptance shall be identical to REQ-025, using the LONG_* inputs and limit LONG_LEN-1, exiting to DATA with LONG_ACK=0 and DATA_ACK=1.
REQ-028 In DATA, each DATA_SYM_VALID=1 cycle shall be forwarded as in REQ-025; DATA_SYM_LAST=1 with VALID shall deassert DATA_ACK and enter END.
REQ-029 A cycle with no valid input shall drive TX_SAMPLE_VALID=0 and TX_SAMPLE=0, and shall hold TX_SAMPLE_INDEX.
REQ-030 Valid inputs that do not belong to the current state (in-flight samples after an ACK drop, or any valid in IDLE/END) shall be discarded: not forwarded, not counted.
REQ-031 In DATA, a 10-bit stall counter shall count consecutive cycles without DATA_SYM_VALID and reset on each valid.
REQ-032 When the stall counter reaches STALL_MAX, the block shall drop all ACKs, pulse TX_ABORT, and return to IDLE without asserting TX_DONE.
REQ-033 END shall last exactly one cycle, pulse TX_DONE, and return to IDLE.
REQ-034 TX_START while TX_BUSY=1 shall be ignored.
REQ-035 TX_START arriving in the same cycle as END shall be ignored.
REQ-036 TX_SAMPLE_INDEX shall wrap modulo 4096.
REQ-037 At most one of SHORT_ACK, LONG_ACK and DATA_ACK shall be high at any time.

Reset
REQ-038 PHY_RST=1 shall immediately force IDLE and set all counters to 0.
REQ-039 PHY_RST=1 shall immediately set SHORT_ACK, LONG_ACK, DATA_ACK, TX_SAMPLE, TX_SAMPLE_VALID, TX_SAMPLE_INDEX, TX_BUSY, TX_DONE and TX_ABORT to 0, independent of SYS_CLK.
REQ-040 A reset asserted mid-frame shall abandon the frame without a TX_DONE or TX_ABORT pulse.

Verification
REQ-041 Normal frame (defaults): TX_START, generators continuously valid, 4 payload samples with LAST on the 4th -> exactly 644 TX_SAMPLE_VALID cycles, indices 0..643, samples in order short/long/data, one TX_DONE.
REQ-042 Gapped input: short valid every other cycle -> still exactly 320 short samples forwarded, TX_SAMPLE_VALID gaps mirror the input, index contiguous.
REQ-043 In-flight discard: short VALID held 1 for the cycle after SHORT_ACK drops -> that sample is not output, and long sample index starts at 320.
REQ-044 Stall: enter DATA, no DATA_SYM_VALID for 1023 cycles -> TX_ABORT pulse, all ACKs 0, TX_BUSY 0 next cycle, no TX_DONE.
REQ-045 Reset mid-LONG at index 400 -> all outputs 0 before the next clock edge; a following TX_START restarts at index 0.
REQ-046 TX_START pulses at index 10 and on the END cycle -> both ignored, and only one frame is transmitted.
